// File: rtl/aes_pkg.sv
// Shared constants and types for the AES core scheduler.
package aes_pkg;

  localparam int DATA_WIDTH      = 128;
  localparam int AES_LATENCY_128 = 11;
  localparam int AES_LATENCY_256 = 15;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// First-word-fall-through response buffer; pointers carry one extra wrap bit
// to tell full from empty.
module aes_sched_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop;
  logic             overflow;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Writes are never refused: the scheduler's credits guarantee space.
  assign overflow  = wr_en_i && full_o && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !overflow);

endmodule

// File: rtl/aes_core_scheduler.sv
// Two-requester round-robin front end for a fixed-latency AES core, with
// credit-based flow control into an in-order response buffer.
module aes_core_scheduler #(
  parameter int DATA_WIDTH = aes_pkg::DATA_WIDTH,
  parameter int LATENCY    = aes_pkg::AES_LATENCY_128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [DATA_WIDTH-1:0] req0_key,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [DATA_WIDTH-1:0] req1_key,
  input  logic                  key_len_cfg,
  output logic                  core_valid_in,
  output logic [DATA_WIDTH-1:0] core_plaintext,
  output logic [DATA_WIDTH-1:0] core_key,
  output logic                  core_keylen,
  input  logic [DATA_WIDTH-1:0] core_ciphertext,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_id,
  output logic                  busy
);

  import aes_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]         credits_q, credits_d;
  logic                  last_grant_q, last_grant_d;
  logic                  keylen_q, keylen_d;
  logic                  cv_q;
  logic                  id_q;
  logic [DATA_WIDTH-1:0] pt_q, key_q;
  tag_t                  tag_q [LATENCY];

  logic                  gnt0, gnt1, issue, pop, any_tag;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH:0]   fifo_rd_data;

  // last_grant_q == 1 means req1 was served last, so req0 wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && (credits_q != '0)) begin
      if (req0_valid && (!req1_valid || last_grant_q)) gnt0 = 1'b1;
      else if (req1_valid)                             gnt1 = 1'b1;
    end
  end

  assign issue      = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    last_grant_d = last_grant_q;
    if (issue) last_grant_d = gnt1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv_q         <= 1'b0;
      id_q         <= 1'b0;
      pt_q         <= '0;
      key_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      cv_q         <= issue;
      last_grant_q <= last_grant_d;
      if (issue) begin
        id_q  <= gnt1;
        pt_q  <= gnt1 ? req1_data : req0_data;
        key_q <= gnt1 ? req1_key  : req0_key;
      end
    end
  end

  assign core_valid_in  = cv_q;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;

  // Tag pipeline tracks the core so each ciphertext lands with its source id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: cv_q, id: id_q};
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < LATENCY; i++) any_tag = any_tag | tag_q[i].valid;
  end

  aes_sched_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (tag_q[LATENCY-1].valid),
    .wr_data_i ({tag_q[LATENCY-1].id, core_ciphertext}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_rd_data[DATA_WIDTH];
  assign rsp_data  = fifo_rd_data[DATA_WIDTH-1:0];
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = any_tag || !fifo_empty || cv_q;

  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // Key length only moves when nothing is in flight; a change while busy
  // simply waits because key_len_cfg is re-sampled every idle cycle.
  always_comb begin
    keylen_d = keylen_q;
    if (!busy && !issue) keylen_d = key_len_cfg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CW'(FIFO_DEPTH);
      keylen_q  <= 1'b0;
    end else begin
      credits_q <= credits_d;
      keylen_q  <= keylen_d;
    end
  end

  assign core_keylen = keylen_q;

  a_credit_range : assert property (@(posedge clk) disable iff (rst)
    credits_q <= CW'(FIFO_DEPTH));

  a_full_no_credit : assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && credits_q != '0));

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a delay-line core model.
module tb_aes_core_scheduler;

  localparam int DW  = 128;
  localparam int LAT = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req0_key, req1_data, req1_key;
  logic          key_len_cfg;
  logic          core_valid_in;
  logic [DW-1:0] core_plaintext, core_key, core_ciphertext;
  logic          core_keylen;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_id;
  logic          busy;

  always #5 clk = ~clk;

  aes_core_scheduler #(.DATA_WIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_data       (req0_data),
    .req0_key        (req0_key),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_data       (req1_data),
    .req1_key        (req1_key),
    .key_len_cfg     (key_len_cfg),
    .core_valid_in   (core_valid_in),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_keylen     (core_keylen),
    .core_ciphertext (core_ciphertext),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_id          (rsp_id),
    .busy            (busy)
  );

  // Core model: ciphertext = plaintext ^ key, LAT cycles after core_valid_in.
  logic [DW-1:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_valid_in ? (core_plaintext ^ core_key) : '0;
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_ciphertext = core_pipe[LAT-1];

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_issue = 0;
  int   n_pop   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Handshakes are sampled just before the edge; outputs settle 1 time unit after it.
  task automatic tick();
    logic hs0, hs1, pp;
    exp_t e;
    #1;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    pp  = rsp_valid && rsp_ready;
    if (hs0) begin
      e.id = 1'b0; e.data = req0_data ^ req0_key;
      exp_q.push_back(e); n_issue++;
    end
    if (hs1) begin
      e.id = 1'b1; e.data = req1_data ^ req1_key;
      exp_q.push_back(e); n_issue++;
    end
    if (pp) begin
      n_pop++;
      if (exp_q.size() == 0) check("rsp_spurious", DW'(rsp_valid), '0);
      else begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_id", DW'(rsp_id), DW'(e.id));
      end
    end
    @(posedge clk);
    #1;
    if (hs0) req0_data = req0_data + 128'h1;
    if (hs1) req1_data = req1_data + 128'h1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d_single, k_single;
    int cnt, base, bad, sp;

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = '0; req0_key = '0;
    req1_data = 128'h1000_0000; req1_key = 128'h5a5a_5a5a;
    key_len_cfg = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();
    #1;
    check("rst_ready", DW'({req1_ready, req0_ready}), '0);
    check("rst_core_valid", DW'(core_valid_in), '0);
    check("rst_rsp_valid", DW'(rsp_valid), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_core_pt", core_plaintext, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_credits", DW'(dut.credits_q), DW'(16));
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Single block
    d_single = 128'h00112233445566778899aabbccddeeff;
    k_single = 128'h000102030405060708090a0b0c0d0e0f;
    req0_data = d_single; req0_key = k_single; req0_valid = 1'b1;
    #1;
    check("single_ready0", DW'(req0_ready), DW'(1));
    tick();
    req0_valid = 1'b0;
    check("single_core_valid", DW'(core_valid_in), DW'(1));
    check("single_core_pt", core_plaintext, d_single);
    check("single_core_key", core_key, k_single);
    check("single_credits_15", DW'(dut.credits_q), DW'(15));
    cnt = 0;
    tick(); cnt++;
    check("single_cv_one_cycle", DW'(core_valid_in), '0);
    while (!rsp_valid && cnt < 40) begin tick(); cnt++; end
    check("single_latency", DW'(cnt), DW'(LAT + 1));
    check("single_rsp_id", DW'(rsp_id), '0);
    check("single_rsp_data", rsp_data, d_single ^ k_single);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("single_credits_16", DW'(dut.credits_q), DW'(16));
    check("single_idle", DW'(busy), '0);

    // Contention: after reset req0 wins first, then strict alternation
    pulse_reset();
    req0_data = 128'h0a00; req0_key = 128'h1111;
    req1_data = 128'h0b00; req1_key = 128'h2222;
    rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    base = n_pop;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_grant", DW'({req1_ready, req0_ready}), (i % 2 == 1) ? DW'(2) : DW'(1));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cnt = 0;
    while ((busy || exp_q.size() != 0) && cnt < 60) begin tick(); cnt++; end
    check("rr_drained", DW'(n_pop - base), DW'(8));

    // Backpressure: exactly 16 credits, then stall
    rsp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    base = n_issue;
    repeat (40) tick();
    check("bp_issue_count", DW'(n_issue - base), DW'(16));
    #1;
    check("bp_ready_low", DW'({req1_ready, req0_ready}), '0);
    check("bp_credits_0", DW'(dut.credits_q), '0);
    check("bp_rsp_valid", DW'(rsp_valid), DW'(1));

    // At zero credits a pop cannot be matched by an issue in the same cycle.
    rsp_ready = 1'b1;
    #1;
    check("zc_no_ready", DW'({req1_ready, req0_ready}), '0);
    tick();
    check("zc_credits_after_pop", DW'(dut.credits_q), DW'(1));
    tick();
    check("zc_pop_issue_hold", DW'(dut.credits_q), DW'(1));
    check("zc_sum_hold", DW'(dut.credits_q) + DW'(n_issue - n_pop), DW'(16));
    rsp_ready = 1'b0;
    tick();
    check("zc_credits_back_0", DW'(dut.credits_q), '0);
    check("zc_outstanding_16", DW'(n_issue - n_pop), DW'(16));

    rsp_ready = 1'b1;
    base = n_issue;
    repeat (20) tick();
    check("bp_resume", DW'(n_issue > base + 10), DW'(1));
    req0_valid = 1'b0; req1_valid = 1'b0;
    cnt = 0;
    while ((busy || exp_q.size() != 0) && cnt < 100) begin tick(); cnt++; end
    check("bp_drain_empty", DW'(exp_q.size()), '0);
    check("bp_credits_16", DW'(dut.credits_q), DW'(16));

    // Key length change while busy is deferred to the first idle cycle
    rsp_ready = 1'b1; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0; key_len_cfg = 1'b1;
    bad = 0; cnt = 0;
    while (busy && cnt < 60) begin
      if (core_keylen !== 1'b0) bad++;
      tick(); cnt++;
    end
    check("kl_held_while_busy", DW'(bad), '0);
    check("kl_now_idle", DW'(busy), '0);
    check("kl_not_yet", DW'(core_keylen), '0);
    tick();
    check("kl_loaded", DW'(core_keylen), DW'(1));

    // Reset with five blocks in flight
    req0_valid = 1'b1; req1_valid = 1'b1;
    base = n_issue;
    repeat (5) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    check("mid_issued_5", DW'(n_issue - base), DW'(5));
    check("mid_busy", DW'(busy), DW'(1));
    rst = 1'b1; req0_valid = 1'b1;
    #1;
    check("mid_rst_ready", DW'({req1_ready, req0_ready}), '0);
    check("mid_rst_busy", DW'(busy), '0);
    check("mid_rst_core_valid", DW'(core_valid_in), '0);
    check("mid_rst_keylen", DW'(core_keylen), '0);
    check("mid_rst_core_key", core_key, '0);
    check("mid_rst_credits", DW'(dut.credits_q), DW'(16));
    req0_valid = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    sp = 0;
    repeat (30) begin
      if (rsp_valid) sp++;
      tick();
    end
    check("mid_no_responses", DW'(sp), '0);
    check("mid_credits_16", DW'(dut.credits_q), DW'(16));
    check("mid_rsp_id", DW'(rsp_id), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
